// File: rtl/battleship_board.sv
// Battleship game board: fixed ship map, per-cell hit/miss memory, one shot
// per rising edge of fire, shot/ship counters, win/loss FSM and a
// column-scanned red/green LED matrix driver with blinking ship reveal.
module battleship_board #(
  parameter int                   ROWS      = 8,
  parameter int                   COLS      = 8,
  parameter logic [ROWS*COLS-1:0] SHIP_MAP  = 64'h4000_0006_2100_2107,
  parameter int                   MAX_SHOTS = 40,
  parameter int                   SCAN_DIV  = 1024,
  parameter int                   BLINK_DIV = 32,
  localparam int                  RW        = $clog2(ROWS),
  localparam int                  CW        = $clog2(COLS),
  localparam int                  SW        = $clog2(ROWS*COLS+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] row_sel,
  input  logic [CW-1:0] col_sel,
  input  logic          fire,
  input  logic          new_game,
  output logic [CW-1:0] scan_col,
  output logic [ROWS-1:0] outR,
  output logic [ROWS-1:0] outG,
  output logic          hit_pulse,
  output logic          miss_pulse,
  output logic          dup_pulse,
  output logic [SW-1:0] shots,
  output logic [SW-1:0] hits_left,
  output logic          game_over,
  output logic          win
);

  localparam int N   = ROWS * COLS;
  localparam int IW  = $clog2(N);
  localparam int SCW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  function automatic int popcnt(input logic [N-1:0] m);
    int n;
    n = 0;
    for (int i = 0; i < N; i++) n += int'(m[i]);
    return n;
  endfunction

  localparam int NSHIP = popcnt(SHIP_MAP);

  typedef enum logic {S_PLAY = 1'b0, S_OVER = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_win, w_win_nxt;
  logic [N-1:0]     r_hit, r_miss;
  logic [SW-1:0]    r_shots, r_left;
  logic             r_fire_d;
  logic             r_hit_p, r_miss_p, r_dup_p;
  logic [SCW-1:0]   r_scan_cnt;
  logic [CW-1:0]    r_scan_col;
  logic [BCW-1:0]   r_frame_cnt;
  logic             r_blink;
  logic [ROWS-1:0]  r_outR, r_outG;
  logic [ROWS-1:0]  w_r, w_g;

  logic             w_shot, w_inrange, w_shot_before, w_ship;
  logic [IW-1:0]    w_idx;
  logic             w_scan_wrap, w_col_wrap;

  // Shot decode: rising edge of fire while playing; new_game takes priority.
  assign w_shot        = fire & ~r_fire_d & (r_state == S_PLAY) & ~new_game;
  assign w_inrange     = (int'(row_sel) < ROWS) && (int'(col_sel) < COLS);
  assign w_idx         = IW'(int'(row_sel) * COLS + int'(col_sel));
  // Out-of-range indices are never used because w_inrange gates every use.
  assign w_shot_before = w_inrange && (r_hit[w_idx] || r_miss[w_idx]);
  assign w_ship        = w_inrange && SHIP_MAP[w_idx];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_PLAY;
      r_win   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
    end
  end

  // FSM next state: game ends the cycle after the deciding shot is recorded;
  // sinking the last ship on the final budgeted shot counts as a win.
  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    if (new_game) begin
      w_state_nxt = S_PLAY;
      w_win_nxt   = 1'b0;
    end else if (r_state == S_PLAY &&
                 (r_left == '0 || r_shots == SW'(MAX_SHOTS))) begin
      w_state_nxt = S_OVER;
      w_win_nxt   = (r_left == '0);
    end
  end

  // Board memory, counters and one-cycle result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit    <= '0;
      r_miss   <= '0;
      r_shots  <= '0;
      r_left   <= SW'(NSHIP);
      r_fire_d <= 1'b0;
      r_hit_p  <= 1'b0;
      r_miss_p <= 1'b0;
      r_dup_p  <= 1'b0;
    end else begin
      r_fire_d <= fire;
      r_hit_p  <= 1'b0;
      r_miss_p <= 1'b0;
      r_dup_p  <= 1'b0;
      if (new_game) begin
        r_hit   <= '0;
        r_miss  <= '0;
        r_shots <= '0;
        r_left  <= SW'(NSHIP);
      end else if (w_shot && w_inrange) begin
        if (w_shot_before) begin
          r_dup_p <= 1'b1;
        end else if (w_ship) begin
          r_hit[w_idx] <= 1'b1;
          r_left       <= r_left - 1'b1;
          r_shots      <= r_shots + 1'b1;
          r_hit_p      <= 1'b1;
        end else begin
          r_miss[w_idx] <= 1'b1;
          r_shots       <= r_shots + 1'b1;
          r_miss_p      <= 1'b1;
        end
      end
    end
  end

  assign w_scan_wrap = (r_scan_cnt == SCW'(SCAN_DIV - 1));
  assign w_col_wrap  = (r_scan_col == CW'(COLS - 1));

  // Free-running column scan and blink timebase (independent of new_game).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_scan_col  <= '0;
      r_frame_cnt <= '0;
      r_blink     <= 1'b0;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
      if (w_scan_wrap) begin
        if (w_col_wrap) begin
          r_scan_col <= '0;
          if (r_frame_cnt == BCW'(BLINK_DIV - 1)) begin
            r_frame_cnt <= '0;
            r_blink     <= ~r_blink;
          end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        end else begin
          r_scan_col <= r_scan_col + 1'b1;
        end
      end
    end
  end

  // Column image: hits red, misses green; yellow cursor while playing,
  // blinking yellow reveal of surviving ship cells once the game is over.
  always_comb begin
    w_r = '0;
    w_g = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (r_hit[IW'(r * COLS + int'(r_scan_col))]) begin
        w_r[r] = 1'b1;
      end else if (r_miss[IW'(r * COLS + int'(r_scan_col))]) begin
        w_g[r] = 1'b1;
      end else if (r_state == S_PLAY) begin
        if (r == int'(row_sel) && r_scan_col == col_sel) begin
          w_r[r] = 1'b1;
          w_g[r] = 1'b1;
        end
      end else if (SHIP_MAP[IW'(r * COLS + int'(r_scan_col))] && r_blink) begin
        w_r[r] = 1'b1;
        w_g[r] = 1'b1;
      end
    end
  end

  // Registered LED drives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outR <= '0;
      r_outG <= '0;
    end else begin
      r_outR <= w_r;
      r_outG <= w_g;
    end
  end

  assign scan_col   = r_scan_col;
  assign outR       = r_outR;
  assign outG       = r_outG;
  assign hit_pulse  = r_hit_p;
  assign miss_pulse = r_miss_p;
  assign dup_pulse  = r_dup_p;
  assign shots      = r_shots;
  assign hits_left  = r_left;
  assign game_over  = (r_state == S_OVER);
  assign win        = r_win;

endmodule

// File: tb/tb_battleship_board.sv
// Directed bench for battleship_board: three boards (default map, 4-shot
// budget, 5x6 custom map) on a shared clock/reset, fast scan timing.
module tb_battleship_board;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // board 0: default map, MAX_SHOTS=40
  logic [2:0] row0 = '0, col0 = '0, sc0;
  logic       fire0 = 1'b0, ng0 = 1'b0;
  logic [7:0] outR0, outG0;
  logic       hit0, miss0, dup0, go0, win0;
  logic [6:0] shots0, left0;
  // board 1: default map, MAX_SHOTS=4
  logic [2:0] row1 = '0, col1 = '0, sc1;
  logic       fire1 = 1'b0, ng1 = 1'b0;
  logic [7:0] outR1, outG1;
  logic       hit1, miss1, dup1, go1, win1;
  logic [6:0] shots1, left1;
  // board 2: 5x6, ships at (0,0),(0,1)
  logic [2:0] row2 = '0, col2 = '0, sc2;
  logic       fire2 = 1'b0, ng2 = 1'b0;
  logic [4:0] outR2, outG2;
  logic       hit2, miss2, dup2, go2, win2;
  logic [4:0] shots2, left2;

  battleship_board #(.ROWS(8), .COLS(8), .MAX_SHOTS(40), .SCAN_DIV(1), .BLINK_DIV(1)) u0 (
    .clk(clk), .rst(rst), .row_sel(row0), .col_sel(col0), .fire(fire0), .new_game(ng0),
    .scan_col(sc0), .outR(outR0), .outG(outG0), .hit_pulse(hit0), .miss_pulse(miss0),
    .dup_pulse(dup0), .shots(shots0), .hits_left(left0), .game_over(go0), .win(win0));

  battleship_board #(.ROWS(8), .COLS(8), .MAX_SHOTS(4), .SCAN_DIV(1), .BLINK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .row_sel(row1), .col_sel(col1), .fire(fire1), .new_game(ng1),
    .scan_col(sc1), .outR(outR1), .outG(outG1), .hit_pulse(hit1), .miss_pulse(miss1),
    .dup_pulse(dup1), .shots(shots1), .hits_left(left1), .game_over(go1), .win(win1));

  battleship_board #(.ROWS(5), .COLS(6), .SHIP_MAP(30'h0000_0003), .MAX_SHOTS(30),
                     .SCAN_DIV(1), .BLINK_DIV(1)) u2 (
    .clk(clk), .rst(rst), .row_sel(row2), .col_sel(col2), .fire(fire2), .new_game(ng2),
    .scan_col(sc2), .outR(outR2), .outG(outG2), .hit_pulse(hit2), .miss_pulse(miss2),
    .dup_pulse(dup2), .shots(shots2), .hits_left(left2), .game_over(go2), .win(win2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] pulses(input int d);
    case (d)
      0:       return {hit0, miss0, dup0};
      1:       return {hit1, miss1, dup1};
      default: return {hit2, miss2, dup2};
    endcase
  endfunction

  function automatic logic [2:0] col_of(input int d);
    case (d)
      0:       return sc0;
      1:       return sc1;
      default: return sc2;
    endcase
  endfunction

  task automatic drive(input int d, input int r, input int c, input logic f);
    case (d)
      0:       begin row0 = 3'(r); col0 = 3'(c); fire0 = f; end
      1:       begin row1 = 3'(r); col1 = 3'(c); fire1 = f; end
      default: begin row2 = 3'(r); col2 = 3'(c); fire2 = f; end
    endcase
  endtask

  // One fire pulse: p = {hit,miss,dup} just after the acting edge,
  // go_n = game_over at that point, p2 = pulses one cycle later.
  task automatic shot(input int d, input int r, input int c,
                      output logic [2:0] p, output logic go_n, output logic [2:0] p2);
    drive(d, r, c, 1'b1);
    tick;
    p    = pulses(d);
    go_n = (d == 0) ? go0 : (d == 1) ? go1 : go2;
    drive(d, r, c, 1'b0);
    tick;
    p2 = pulses(d);
  endtask

  // Wait (bounded) until scan_col == c; the LED outputs then show column c-1.
  task automatic wait_col(input int d, input int c, input string tag);
    logic ok;
    ok = 1'b0;
    tick;
    for (int k = 0; k < 64; k++) begin
      if (int'(col_of(d)) == c) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
    chk(tag, ok, 1'b1);
  endtask

  logic [2:0] p, p2;
  logic       gon;
  int         nh, nmd;
  logic [7:0] ra, ga;
  int         sr[8] = '{0, 0, 1, 3, 3, 4, 4, 7};
  int         scl[8] = '{1, 2, 5, 0, 5, 1, 2, 6};

  initial begin
    // ---------------- reset ----------------
    tick; tick; tick;
    chk("rst_shots", shots0, 0);
    chk("rst_left0", left0, 10);
    chk("rst_go", go0, 0);
    chk("rst_win", win0, 0);
    chk("rst_led", {outR0, outG0}, 0);
    chk("rst_scan", sc0, 0);
    chk("rst_left2", left2, 2);
    rst = 1'b0;
    tick;

    // ---------------- board 0: basic hit / miss / dup ----------------
    shot(0, 0, 0, p, gon, p2);
    chk("hit00_pulse", p, 3'b100);
    chk("hit00_pulse_end", p2, 3'b000);
    chk("hit00_shots", shots0, 1);
    chk("hit00_left", left0, 9);
    wait_col(0, 1, "wait_col0");
    chk("col0_led", {outR0, outG0}, 16'h0100);

    shot(0, 0, 3, p, gon, p2);
    chk("miss03_pulse", p, 3'b010);
    chk("miss03_shots", shots0, 2);
    chk("miss03_left", left0, 9);
    wait_col(0, 4, "wait_col3");
    chk("col3_led", {outR0, outG0}, 16'h0001);

    shot(0, 0, 3, p, gon, p2);
    chk("dup03_pulse", p, 3'b001);
    chk("dup03_shots", shots0, 2);

    // held fire: one shot only; moving the target while held does nothing
    drive(0, 1, 0, 1'b1);
    nh = 0; nmd = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) row0 = 3'd2;
      tick;
      nh  += int'(hit0);
      nmd += int'(miss0) + int'(dup0);
    end
    fire0 = 1'b0;
    tick;
    chk("held_hits", nh, 1);
    chk("held_other", nmd, 0);
    chk("held_shots", shots0, 3);
    chk("held_left", left0, 8);

    // cursor on an unshot empty cell shows yellow; unhit ships stay hidden
    drive(0, 5, 5, 1'b0);
    wait_col(0, 6, "wait_col5");
    chk("cursor_led", {outR0, outG0}, 16'h2020);

    // sink the remaining eight ships
    for (int i = 0; i < 8; i++) begin
      shot(0, sr[i], scl[i], p, gon, p2);
      chk($sformatf("sink%0d_pulse", i), p, 3'b100);
    end
    chk("sink_go_at_shot", gon, 0);
    chk("sink_over", go0, 1);
    chk("sink_win", win0, 1);
    chk("sink_shots", shots0, 11);
    chk("sink_left", left0, 0);

    shot(0, 6, 6, p, gon, p2);
    chk("over_ignored", p, 3'b000);
    chk("over_shots", shots0, 11);

    ng0 = 1'b1; tick; ng0 = 1'b0;
    chk("ng_shots", shots0, 0);
    chk("ng_left", left0, 10);
    chk("ng_over", go0, 0);
    chk("ng_win", win0, 0);
    wait_col(0, 1, "wait_ng_col0");
    chk("ng_col0_led", {outR0, outG0}, 16'h0000);

    // ---------------- board 1: shot budget exhausted ----------------
    for (int i = 0; i < 4; i++) begin
      shot(1, 2, i, p, gon, p2);
      chk($sformatf("budget%0d_pulse", i), p, 3'b010);
    end
    chk("budget_go_at_shot", gon, 0);
    chk("budget_shots", shots1, 4);
    chk("budget_over", go1, 1);
    chk("budget_win", win1, 0);
    wait_col(1, 1, "wait_blink_a");
    ra = outR1; ga = outG1;
    wait_col(1, 1, "wait_blink_b");
    chk("blink_red", ra ^ outR1, 8'h0B);
    chk("blink_grn", ga ^ outG1, 8'h0B);
    chk("blink_miss_steady", ga & outG1, 8'h04);
    ng1 = 1'b1; tick; ng1 = 1'b0;
    chk("ng1_over", go1, 0);
    chk("ng1_shots", shots1, 0);

    // ---------------- board 2: 5x6 ----------------
    shot(2, 6, 0, p, gon, p2);
    chk("oor_row", {p, p2}, 6'b0);
    shot(2, 0, 7, p, gon, p2);
    chk("oor_col", {p, p2}, 6'b0);
    chk("oor_shots", shots2, 0);
    wait_col(2, 5, "wait_col5_b2");
    tick;
    chk("scan_wrap", sc2, 0);

    drive(2, 0, 0, 1'b1);
    ng2 = 1'b1;
    tick;
    chk("ng_fire_pulse", pulses(2), 3'b000);
    ng2 = 1'b0;
    tick;
    chk("ng_fire_held", pulses(2), 3'b000);
    fire2 = 1'b0;
    tick;
    chk("ng_fire_shots", shots2, 0);
    chk("ng_fire_left", left2, 2);
    shot(2, 0, 0, p, gon, p2);
    chk("b2_hit", p, 3'b100);
    chk("b2_left", left2, 1);
    shot(2, 4, 5, p, gon, p2);
    chk("b2_miss", p, 3'b010);
    chk("b2_shots", shots2, 2);

    // ---------------- asynchronous reset mid-game ----------------
    shot(0, 0, 0, p, gon, p2);
    chk("pre_rst_shots", shots0, 1);
    rst = 1'b1;
    #1;
    chk("arst_shots", shots0, 0);
    chk("arst_left", left0, 10);
    chk("arst_led", {outR0, outG0}, 16'h0000);
    chk("arst_scan", sc0, 0);
    chk("arst_b2_shots", shots2, 0);
    tick;
    rst = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
